// File: rtl/montgomery_mult_param.sv
// montgomery_mult_param: iterative Montgomery multiplier, out = x*y*2^-NBITS mod n, RADIX_BITS bits per clock
module montgomery_mult_param #(
  parameter int NBITS      = 256,
  parameter int RADIX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] x,
  input  logic [NBITS-1:0] y,
  input  logic [NBITS-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] out
);
  localparam int K  = NBITS / RADIX_BITS;
  localparam int CW = $clog2(K + 1);
  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;
  state_t           state_q, state_d;
  logic [NBITS-1:0] x_q, x_d, y_q, y_d, n_q, n_d, out_q, out_d, a_sub;
  logic [NBITS+1:0] a_q, a_d, a_step;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  // A stays below 2n between steps, so the two guard bits hold every intermediate (< 4n)
  always_comb begin
    a_step = a_q;
    for (int i = 0; i < RADIX_BITS; i++) begin
      a_step = a_step + (x_q[i] ? {2'b00, y_q} : '0);
      a_step = a_step + (a_step[0] ? {2'b00, n_q} : '0);
      a_step = a_step >> 1;
    end
  end
  // A < 2n at the end, so A - n fits in NBITS and only the low bits are needed
  assign a_sub = a_q[NBITS-1:0] - n_q;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        x_d     = x;
        y_d     = y;
        n_d     = n;
        a_d     = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_step;
        x_d     = x_q >> RADIX_BITS;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(K - 1)) ? FINAL : RUN;
      end
      FINAL: begin
        out_d   = (a_q >= {2'b00, n_q}) ? a_sub : a_q[NBITS-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign out  = out_q;
endmodule

// File: tb/tb_montgomery_mult_param.sv
// tb_montgomery_mult_param: scoreboard bench for an 8-bit, radix-4 Montgomery multiplier
module tb_montgomery_mult_param;
  localparam int NB = 8;
  localparam int RB = 2;
  localparam int K  = NB / RB;
  typedef struct {
    int e;
    int n;
    int cyc;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] x = '0, y = '0, n = '0;
  logic          busy, done;
  logic [NB-1:0] out;
  exp_t          exp_q[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  montgomery_mult_param #(.NBITS(NB), .RADIX_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .n(n),
    .busy(busy), .done(done), .out(out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t t;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got out=%0d at cycle %0d, expected no done", out, cyc);
      end else begin
        t = exp_q.pop_front();
        check("out", int'(out), t.e);
        check("out_lt_n", int'(int'(out) < t.n), 1);
        check("done_cycle", cyc, t.cyc);
        check("busy_with_done", int'(busy), 0);
      end
    end
  end
  // Start accepted at the next posedge E0; done is seen at the negedge after E0+K+1
  task automatic issue(input int xi, input int yi, input int ni, input int e);
    @(negedge clk);
    x = NB'(xi); y = NB'(yi); n = NB'(ni); start = 1'b1;
    exp_q.push_back('{e, ni, cyc + K + 2});
    @(negedge clk);
    start = 1'b0; x = ~NB'(xi); y = ~NB'(yi); n = NB'(ni) ^ 8'h06;
    repeat (K + 1) @(negedge clk);
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (K + 3) @(negedge clk);
    check(nm, exp_q.size(), 0);
  endtask
  int vx[10] = '{5, 12, 2, 12, 0, 254, 250, 100, 6, 2};
  int vy[10] = '{7, 12, 3, 1, 9, 254, 250, 3, 5, 2};
  int vn[10] = '{13, 13, 13, 13, 13, 255, 251, 251, 7, 3};
  int ve[10] = '{1, 3, 5, 10, 0, 1, 201, 60, 4, 1};
  initial begin
    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out", int'(out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) issue(vx[i], vy[i], vn[i], ve[i]);
    drain("directed_drained");
    // start held high: three operations spaced K+2 cycles apart
    @(negedge clk);
    x = 8'd12; y = 8'd12; n = 8'd13; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back('{3, 13, cyc + K + 2 + i * (K + 2)});
    repeat (2 * (K + 2) + 1) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain("held_start_drained");
    // start pulses while busy must be ignored
    @(negedge clk);
    x = 8'd5; y = 8'd7; n = 8'd13; start = 1'b1;
    exp_q.push_back('{1, 13, cyc + K + 2});
    @(negedge clk); start = 1'b0; x = 8'd2; y = 8'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    drain("busy_start_drained");
    check("out_hold", int'(out), 1);
    // async reset mid-RUN aborts the operation and clears out
    @(negedge clk);
    x = 8'd12; y = 8'd1; n = 8'd13; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_out", int'(out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(6, 5, 7, 4);
    issue(12, 1, 13, 10);
    drain("post_reset_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/montgomery_mult_param.md
Name: montgomery_mult_param

Overview:
- Parametrised, iterative Montgomery modular multiplier: out = x * y * 2^(-NBITS) mod n.
- Processes RADIX_BITS multiplier bits per clock.
- Has a start/busy/done handshake and a final conditional subtraction, so the result is fully reduced (out < n).
- Building block for the RSA/modular-exponentiation datapath; the exponentiation controller instantiates it and issues back-to-back multiplies.

Parameters:
- NBITS, 256, operand and modulus width; must be a multiple of RADIX_BITS.
- RADIX_BITS, 2, multiplier bits consumed per iteration cycle; legal values 1, 2, 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled request; accepted only on a rising edge of clk while in IDLE.
- x  input  NBITS  multiplicand (scanned LSB first); requires x < n.
- y  input  NBITS  multiplier operand; requires y < n.
- n  input  NBITS  modulus; must be odd, n > 1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out becomes valid.
- out  output  NBITS  result; held stable until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, out=0, accumulator=0, counter=0. A reset mid-operation aborts the operation; no done pulse is produced for it.
- Let K = NBITS/RADIX_BITS.
- States: IDLE -> RUN -> FINAL -> IDLE.
- IDLE:
  - On an edge with start=1, latch x, y, n into internal registers.
  - Clear accumulator A (NBITS+2 bits) and counter; set busy=1; go to RUN.
  - Inputs may change freely after the accepting edge.
- RUN: each edge performs RADIX_BITS chained radix-2 steps, LSB of the x shift register first. Per step:
  - A = A + (xi ? y : 0)
  - if A[0]: A = A + n
  - A = A >> 1
- RUN, after each edge: the x shift register shifts right by RADIX_BITS and the counter increments. After K RUN edges, go to FINAL.
- Width invariant: A < 2n at every step boundary. Intermediates never exceed 4n, so NBITS+2 bits suffice; no truncation is allowed.
- FINAL, one edge:
  - out = (A >= n) ? A - n : A[NBITS-1:0]
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: with start accepted at edge E0, done is high for the cycle following edge E0+K+1. For NBITS=256, RADIX_BITS=2, that is edge E0+129.
- busy is high from the E0 edge through the cycle before done rises. busy and done are never high together.
- start while busy: ignored, with no effect on the running operation.
- start held high continuously: a new operation is accepted on the edge after done is emitted, i.e. while in IDLE. Back-to-back issue therefore costs K+2 cycles per multiply.
- start=1 on the edge where done pulses: not accepted. The FSM is in FINAL on that edge.
- out changes only at FINAL edges and at reset. Between operations it holds the last result.
- x=0 or y=0 gives out=0.
- Even n: result undefined, but the FSM timing is unchanged and no lockup is allowed.

Test Plan:
- NBITS=8, RADIX_BITS=2, n=13, x=5, y=7, start pulsed one cycle -> busy high for 5 cycles, done pulse at E0+5, out=1 (35*3 mod 13, since 2^-8 mod 13 = 3).
- Same configuration, x=12, y=12 -> out=3; check out < n. Repeat with RADIX_BITS=1 (done at E0+9) and RADIX_BITS=4 (done at E0+3) -> identical out=3.
- Same configuration, x=0, y=9 -> out=0. Then change x, y, n two cycles after the start edge -> result is unaffected (computed from latched operands).
- start held high across 3 operations -> exactly 3 done pulses spaced K+2 cycles apart. start pulses during busy -> no extra operation, out unchanged.
- Drive rst_n=0 for 1 cycle mid-RUN -> busy=0, done=0, out=0 immediately (async). A subsequent start completes normally with the correct result.
- NBITS=256, RADIX_BITS=2, 1000 random odd n with x, y < n, compared against a software reference model -> all match, done at E0+129, out < n.
